// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//
// Shared definitions for the AES round datapath blocks.
//   - state_t      : engine FSM states (IDLE / CALC / DONE)
//   - GF_RED       : reduction constant applied when a byte shifted left
//                    overflows bit 7 (low byte of x^8+x^4+x^3+x+1)
//   - MIX_FWD_ROW  : MixColumns coefficient row 0, packed {c0,c1,c2,c3}
//   - MIX_INV_ROW  : InvMixColumns coefficient row 0, packed {c0,c1,c2,c3}
// Row r of either matrix is row 0 rotated right by r byte positions.
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]  GF_RED      = 8'h1B;
  localparam logic [31:0] MIX_FWD_ROW = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [31:0] MIX_INV_ROW = {8'h0E, 8'h0B, 8'h0D, 8'h09};

  // Rotate a packed coefficient row right by r byte positions.
  function automatic logic [31:0] rot_row(input logic [31:0] row0,
                                          input logic [1:0]  r);
    logic [31:0] res;
    case (r)
      2'd0:    res = row0;
      2'd1:    res = {row0[7:0],  row0[31:8]};
      2'd2:    res = {row0[15:0], row0[31:16]};
      default: res = {row0[23:0], row0[31:24]};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gf_mul.sv
// ---------------------------------------------------------------------------
// gf_mul
//
// Combinational 8x8 multiplier over GF(2^8) with field polynomial 0x11B.
// Shift-and-XOR: for each set bit of b the current multiple of a is XORed
// into the product, and a is doubled (xtime) with a conditional 0x1B
// reduction. All intermediates stay 8 bits wide.
//
// Ports:
//   a  input  [7:0]  multiplicand
//   b  input  [7:0]  multiplier
//   p  output [7:0]  product a*b in GF(2^8)
// ---------------------------------------------------------------------------
module gf_mul
  import aes_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic [7:0] mult;

  always_comb begin
    acc  = 8'h00;
    mult = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ mult;
      end
      // xtime: shift left, fold the overflow bit back with 0x1B
      if (mult[7]) begin
        mult = {mult[6:0], 1'b0} ^ GF_RED;
      end else begin
        mult = {mult[6:0], 1'b0};
      end
    end
  end

  assign p = acc;

endmodule

// File: rtl/mix_column_seq.sv
// ---------------------------------------------------------------------------
// mix_column_seq
//
// Sequential AES MixColumns engine. One 32-bit column is accepted, then one
// output row is computed per cycle (four GF(2^8) products XORed together),
// and the finished column is presented with a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds data and valid stable until that edge; ready
// may be high without valid. in_valid is ignored while in_ready is low.
//
// Optional build macro INV_MIX_EN: adds the inv port; inv=1 at acceptance
// selects the InvMixColumns coefficients. Without it only the forward
// coefficients exist.
//
// Ports:
//   clk        input        rising-edge clock
//   rst        input        synchronous active-high reset
//   in_valid   input        col_in valid
//   in_ready   output       engine idle and able to accept a column
//   col_in     input [31:0] column, [31:24]=a0 (row 0) .. [7:0]=a3
//   inv        input        (INV_MIX_EN only) 1 = InvMixColumns
//   out_valid  output       col_out valid
//   out_ready  input        consumer accepts col_out
//   col_out    output[31:0] result column, [31:24]=b0 .. [7:0]=b3
//   busy       output       engine not idle
//
// Timing: acceptance edge E0, rows 0..3 written on E1..E4, DONE and
// out_valid from E4; with out_ready high the handshake is at E5 and the
// next acceptance at E6.
// ---------------------------------------------------------------------------
module mix_column_seq
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] col_in,
`ifdef INV_MIX_EN
  input  logic        inv,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] col_out,
  output logic        busy
);

  state_t      state;
  logic [1:0]  r;
  logic [31:0] work;
  logic [31:0] result;
  logic [31:0] next_result;
  logic [31:0] row0;
  logic [31:0] coef;
  logic [7:0]  term [4];
  logic [7:0]  b_r;

`ifdef INV_MIX_EN
  logic inv_q;
  assign row0 = inv_q ? MIX_INV_ROW : MIX_FWD_ROW;
`else
  assign row0 = MIX_FWD_ROW;
`endif

  assign coef = rot_row(row0, r);

  // Four products of the current row: coef byte j times column byte j.
  for (genvar j = 0; j < 4; j++) begin : g_term
    gf_mul u_gf_mul (
      .a (coef[31-8*j -: 8]),
      .b (work[31-8*j -: 8]),
      .p (term[j])
    );
  end

  assign b_r = term[0] ^ term[1] ^ term[2] ^ term[3];

  // Result register with byte r replaced by the current row's output.
  always_comb begin
    next_result = result;
    case (r)
      2'd0:    next_result[31:24] = b_r;
      2'd1:    next_result[23:16] = b_r;
      2'd2:    next_result[15:8]  = b_r;
      default: next_result[7:0]   = b_r;
    endcase
  end

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r         <= 2'd0;
      work      <= 32'h0;
      result    <= 32'h0;
      col_out   <= 32'h0;
      out_valid <= 1'b0;
`ifdef INV_MIX_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= col_in;
            r     <= 2'd0;
`ifdef INV_MIX_EN
            inv_q <= inv;
`endif
            state <= CALC;
          end
        end
        CALC: begin
          result <= next_result;
          r      <= r + 2'd1;
          if (r == 2'd3) begin
            // next_result already holds row 3, so the whole column
            // lands in col_out in a single write.
            col_out   <= next_result;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
